uart_boot_loader: RTL and testbench

Parametrised successor to the UART program loader. Receives framed program images over a UART and writes them into the instruction ROM/RAM word by word, at a start address given in the frame. Each frame carries a word count and a checksum, and the block answers every completed frame with an ACK or NAK byte on tx. Sits between the host UART pins and the program-memory write port, and holds the AVR-like core in reset while a frame is being loaded.

---
 rtl/uart_boot_pkg.sv | 23 ++
 rtl/uart_boot_loader_uart_rx.sv | 90 +++++++++
 rtl/uart_boot_loader.sv | 224 ++++++++++++++++++++++
 tb/tb_uart_boot_loader.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_boot_pkg.sv
// Shared constants, frame FSM states and baud helper for the UART boot loader.
package uart_boot_pkg;

  localparam logic [7:0] SYNC = 8'hA5;
  localparam logic [7:0] ACK  = 8'h06;
  localparam logic [7:0] NAK  = 8'h15;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR_H,
    ST_ADDR_L,
    ST_CNT_H,
    ST_CNT_L,
    ST_DATA,
    ST_CHK,
    ST_ACK
  } state_e;

  function automatic int unsigned calc_div(input int unsigned clk_hz, input int unsigned baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_boot_loader_uart_rx.sv
// UART receiver: 2-flop synchroniser, mid-bit start validation, LSB-first sampling,
// one-cycle byte_valid / byte_err pulses depending on the stop bit.
module uart_rx #(
  parameter int unsigned DIV = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       byte_err
);

  localparam int unsigned CW = $clog2(DIV + 1);
  localparam logic [CW-1:0] HALF = CW'((DIV / 2 > 0) ? DIV / 2 - 1 : 0);
  localparam logic [CW-1:0] FULL = CW'(DIV - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  rx_state_e     st_q, st_d;
  logic          rx_m_q, rx_s_q, rx_p_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_m_q  <= 1'b1;
      rx_s_q  <= 1'b1;
      rx_p_q  <= 1'b1;
      st_q    <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      rx_m_q  <= rx;
      rx_s_q  <= rx_m_q;
      rx_p_q  <= rx_s_q;
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    sh_d    = sh_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    case (st_q)
      // Edge-triggered start so a low stop bit cannot retrigger a phantom byte.
      RX_IDLE: begin
        cnt_d = '0;
        if (rx_p_q && !rx_s_q) st_d = RX_START;
      end
      RX_START: if (cnt_q == HALF) begin
        cnt_d = '0;
        bit_d = '0;
        st_d  = rx_s_q ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (cnt_q == FULL) begin
        cnt_d = '0;
        sh_d  = {rx_s_q, sh_q[7:1]};
        bit_d = bit_q + 3'd1;
        if (bit_q == 3'd7) st_d = RX_STOP;
      end
      RX_STOP: if (cnt_q == FULL) begin
        cnt_d   = '0;
        valid_d = rx_s_q;
        err_d   = !rx_s_q;
        st_d    = RX_IDLE;
      end
      default: st_d = RX_IDLE;
    endcase
  end

  assign byte_data  = sh_q;
  assign byte_valid = valid_q;
  assign byte_err   = err_q;

endmodule

// File: rtl/uart_boot_loader.sv
// Framed UART program loader: parses A5/addr/count/payload/checksum frames, writes
// program memory word by word, and replies ACK/NAK on tx while holding the core.
module uart_boot_loader
  import uart_boot_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 50000000,
  parameter int unsigned BAUD        = 115200,
  parameter int unsigned WORD_BYTES  = 2,
  parameter int unsigned ADDR_W      = 12,
  parameter bit          MSB_FIRST   = 1'b1,
  parameter int unsigned TIMEOUT_CYC = CLK_HZ / 100
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rx,
  output logic                    tx,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [8*WORD_BYTES-1:0] mem_data,
  output logic                    mem_we,
  output logic                    core_hold,
  output logic                    busy,
  output logic                    err_crc,
  output logic                    err_frm
);

  localparam int unsigned DIV   = calc_div(CLK_HZ, BAUD);
  localparam int unsigned DW    = 8 * WORD_BYTES;
  localparam int unsigned IDX_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam int unsigned TW    = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned DCW   = $clog2(DIV + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_BYTES - 1);
  localparam logic [TW-1:0]    TO_LAST  = TW'(TIMEOUT_CYC - 1);
  localparam logic [DCW-1:0]   TX_LAST  = DCW'(DIV - 1);

  logic [7:0] rx_byte;
  logic       rx_valid, rx_err;

  uart_rx #(.DIV(DIV)) u_rx (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .byte_data (rx_byte),
    .byte_valid(rx_valid),
    .byte_err  (rx_err)
  );

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        addr_h_q, addr_h_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [7:0]        cnt_h_q, cnt_h_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DW-1:0]     word_q, word_d, word_ins;
  logic [7:0]        sum_q, sum_d;
  logic [TW-1:0]     to_q, to_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0]     mem_data_q, mem_data_d;
  logic              hold_q, hold_d;
  logic              err_crc_q, err_crc_d;
  logic              err_frm_q, err_frm_d;
  logic [9:0]        tx_sh_q, tx_sh_d;
  logic [3:0]        tx_bit_q, tx_bit_d;
  logic [DCW-1:0]    tx_cnt_q, tx_cnt_d;
  logic              in_frame;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      addr_h_q   <= '0;
      cnt_q      <= '0;
      cnt_h_q    <= '0;
      idx_q      <= '0;
      word_q     <= '0;
      sum_q      <= '0;
      to_q       <= '0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      hold_q     <= 1'b0;
      err_crc_q  <= 1'b0;
      err_frm_q  <= 1'b0;
      tx_sh_q    <= '1;
      tx_bit_q   <= '0;
      tx_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      addr_h_q   <= addr_h_d;
      cnt_q      <= cnt_d;
      cnt_h_q    <= cnt_h_d;
      idx_q      <= idx_d;
      word_q     <= word_d;
      sum_q      <= sum_d;
      to_q       <= to_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      hold_q     <= hold_d;
      err_crc_q  <= err_crc_d;
      err_frm_q  <= err_frm_d;
      tx_sh_q    <= tx_sh_d;
      tx_bit_q   <= tx_bit_d;
      tx_cnt_q   <= tx_cnt_d;
    end
  end

  // Drop the incoming byte into its lane; lane order depends on MSB_FIRST.
  always_comb begin
    word_ins = word_q;
    for (int b = 0; b < WORD_BYTES; b++) begin
      if (IDX_W'(MSB_FIRST ? WORD_BYTES - 1 - b : b) == idx_q) word_ins[8*b +: 8] = rx_byte;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    addr_h_d   = addr_h_q;
    cnt_d      = cnt_q;
    cnt_h_d    = cnt_h_q;
    idx_d      = idx_q;
    word_d     = word_q;
    sum_d      = sum_q;
    to_d       = '0;
    mem_we_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    hold_d     = hold_q;
    err_crc_d  = err_crc_q;
    err_frm_d  = err_frm_q;
    tx_sh_d    = tx_sh_q;
    tx_bit_d   = tx_bit_q;
    tx_cnt_d   = tx_cnt_q;
    in_frame   = (state_q == ST_ADDR_H) || (state_q == ST_ADDR_L) || (state_q == ST_CNT_H) ||
                 (state_q == ST_CNT_L)  || (state_q == ST_DATA)   || (state_q == ST_CHK);

    if (in_frame) begin
      to_d = rx_valid ? '0 : to_q + 1'b1;
      if (rx_valid) sum_d = sum_q + rx_byte;
    end

    if (in_frame && (rx_err || (!rx_valid && to_q == TO_LAST))) begin
      err_frm_d = 1'b1;
      hold_d    = 1'b0;
      state_d   = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (rx_valid && rx_byte == SYNC) begin
          err_crc_d = 1'b0;
          err_frm_d = 1'b0;
          hold_d    = 1'b1;
          sum_d     = '0;
          idx_d     = '0;
          state_d   = ST_ADDR_H;
        end
        ST_ADDR_H: if (rx_valid) begin
          addr_h_d = rx_byte;
          state_d  = ST_ADDR_L;
        end
        ST_ADDR_L: if (rx_valid) begin
          addr_d  = ADDR_W'({addr_h_q, rx_byte});
          state_d = ST_CNT_H;
        end
        ST_CNT_H: if (rx_valid) begin
          cnt_h_d = rx_byte;
          state_d = ST_CNT_L;
        end
        ST_CNT_L: if (rx_valid) begin
          cnt_d   = {cnt_h_q, rx_byte};
          idx_d   = '0;
          state_d = ({cnt_h_q, rx_byte} == 16'd0) ? ST_CHK : ST_DATA;
        end
        ST_DATA: if (rx_valid) begin
          word_d = word_ins;
          if (idx_q == LAST_IDX) begin
            mem_we_d   = 1'b1;
            mem_addr_d = addr_q;
            mem_data_d = word_ins;
            addr_d     = addr_q + 1'b1;
            cnt_d      = cnt_q - 16'd1;
            idx_d      = '0;
            if (cnt_q == 16'd1) state_d = ST_CHK;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
        ST_CHK: if (rx_valid) begin
          tx_sh_d  = {1'b1, (rx_byte == sum_q) ? ACK : NAK, 1'b0};
          tx_bit_d = '0;
          tx_cnt_d = '0;
          if (rx_byte != sum_q) err_crc_d = 1'b1;
          state_d  = ST_ACK;
        end
        // Shift register refills with 1s, so tx idles high once the stop bit is out.
        ST_ACK: begin
          if (tx_cnt_q == TX_LAST) begin
            tx_cnt_d = '0;
            tx_sh_d  = {1'b1, tx_sh_q[9:1]};
            tx_bit_d = tx_bit_q + 4'd1;
            if (tx_bit_q == 4'd9) begin
              hold_d  = 1'b0;
              state_d = ST_IDLE;
            end
          end else begin
            tx_cnt_d = tx_cnt_q + 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign tx        = tx_sh_q[0];
  assign mem_addr  = mem_addr_q;
  assign mem_data  = mem_data_q;
  assign mem_we    = mem_we_q;
  assign core_hold = hold_q;
  assign busy      = (state_q != ST_IDLE);
  assign err_crc   = err_crc_q;
  assign err_frm   = err_frm_q;

endmodule

// File: tb/tb_uart_boot_loader.sv
// Bench for uart_boot_loader: two configurations, frames built and scored by a byte-level model.
module tb_uart_boot_loader;

  localparam int CLK_HZ = 1000000;
  localparam int BAUD   = 100000;
  localparam int DIV    = CLK_HZ / BAUD;
  localparam int TO     = 3000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx_a = 1'b1, rx_b = 1'b1;
  logic tx_a, tx_b;
  logic [11:0] addr_a;
  logic [15:0] data_a;
  logic [3:0]  addr_b;
  logic [31:0] data_b;
  logic we_a, hold_a, busy_a, ecrc_a, efrm_a;
  logic we_b, hold_b, busy_b, ecrc_b, efrm_b;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  uart_boot_loader #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .TIMEOUT_CYC(TO)) dut_a (
    .clk(clk), .rst(rst), .rx(rx_a), .tx(tx_a), .mem_addr(addr_a), .mem_data(data_a),
    .mem_we(we_a), .core_hold(hold_a), .busy(busy_a), .err_crc(ecrc_a), .err_frm(efrm_a));

  uart_boot_loader #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .WORD_BYTES(4), .ADDR_W(4),
                     .MSB_FIRST(1'b0), .TIMEOUT_CYC(TO)) dut_b (
    .clk(clk), .rst(rst), .rx(rx_b), .tx(tx_b), .mem_addr(addr_b), .mem_data(data_b),
    .mem_we(we_b), .core_hold(hold_b), .busy(busy_b), .err_crc(ecrc_b), .err_frm(efrm_b));

  // Observed traffic: writes as {addr16, data32}, replies with core_hold seen at the stop bit.
  logic [47:0] wr_a[$], wr_b[$], got_wr[$], exp_wr[$];
  logic [7:0]  rep_a[$], rep_b[$], got_rep[$], frm[$];
  logic        hb_a[$], hb_b[$], got_hb[$];
  logic [31:0] words[$];
  logic [7:0]  exp_rep;

  always @(negedge clk) begin
    if (we_a === 1'b1) wr_a.push_back({4'b0, addr_a, 16'b0, data_a});
    if (we_b === 1'b1) wr_b.push_back({12'b0, addr_b, data_b});
  end

  task automatic tx_watch(input int which);
    logic [7:0] b;
    logic h;
    forever begin
      @(negedge clk);
      if ((which ? tx_b : tx_a) === 1'b0) begin
        repeat (DIV / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (DIV) @(negedge clk);
          b[i] = which ? tx_b : tx_a;
        end
        repeat (DIV) @(negedge clk);
        h = which ? hold_b : hold_a;
        if (which != 0) begin rep_b.push_back(b); hb_b.push_back(h); end
        else begin rep_a.push_back(b); hb_a.push_back(h); end
      end
    end
  endtask

  initial tx_watch(0);
  initial tx_watch(1);

  function automatic logic [3:0] flags(input int which);
    return (which != 0) ? {hold_b, busy_b, ecrc_b, efrm_b} : {hold_a, busy_a, ecrc_a, efrm_a};
  endfunction

  task automatic set_rx(input int which, input logic v);
    if (which != 0) rx_b = v; else rx_a = v;
  endtask

  task automatic send_byte(input int which, input logic [7:0] b, input logic stop);
    set_rx(which, 1'b0);
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      set_rx(which, b[i]);
      repeat (DIV) @(negedge clk);
    end
    set_rx(which, stop);
    repeat (DIV) @(negedge clk);
    set_rx(which, 1'b1);
    repeat (3) @(negedge clk);
  endtask

  // Reference: frame bytes, expected writes and reply derived from the frame rules directly.
  task automatic make_frame(input int which, input logic [15:0] a, input bit bad);
    int wb, aw, bi;
    bit msb;
    logic [7:0] s;
    logic [15:0] n;
    wb = (which != 0) ? 4 : 2;
    aw = (which != 0) ? 4 : 12;
    msb = (which == 0);
    n = 16'(words.size());
    frm.delete();
    exp_wr.delete();
    frm.push_back(8'hA5);
    frm.push_back(a[15:8]);
    frm.push_back(a[7:0]);
    frm.push_back(n[15:8]);
    frm.push_back(n[7:0]);
    foreach (words[k]) begin
      for (int j = 0; j < wb; j++) begin
        bi = msb ? wb - 1 - j : j;
        frm.push_back(words[k][8*bi +: 8]);
      end
      exp_wr.push_back({16'((int'(a) + k) % (1 << aw)), words[k]});
    end
    s = 8'h00;
    for (int i = 1; i < frm.size(); i++) s += frm[i];
    exp_rep = bad ? 8'h15 : 8'h06;
    frm.push_back(bad ? s + 8'($urandom_range(1, 255)) : s);
  endtask

  task automatic send_frm(input int which);
    if (which != 0) begin wr_b.delete(); rep_b.delete(); hb_b.delete(); end
    else begin wr_a.delete(); rep_a.delete(); hb_a.delete(); end
    foreach (frm[i]) send_byte(which, frm[i], 1'b1);
  endtask

  task automatic wait_collect(input int which, input int max_cyc);
    for (int c = 0; c < max_cyc; c++) begin
      if (((which != 0) ? rep_b.size() : rep_a.size()) != 0) break;
      @(negedge clk);
    end
    repeat (DIV) @(negedge clk);
    if (which != 0) begin got_wr = wr_b; got_rep = rep_b; got_hb = hb_b; end
    else begin got_wr = wr_a; got_rep = rep_a; got_hb = hb_a; end
  endtask

  function automatic logic [7:0] rep0();
    if (got_rep.size() == 0) return 8'hxx;
    return got_rep[0];
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (5) @(negedge clk);
    n_chk++;
    if ({tx_a, addr_a, data_a, we_a} !== {1'b1, 12'h0, 16'h0, 1'b0})
      $display("FAIL reset_a_bus: got %h required %h", {tx_a, addr_a, data_a, we_a}, {1'b1, 29'h0});
    else n_pass++;
    n_chk++;
    if ({tx_b, addr_b, data_b, we_b} !== {1'b1, 4'h0, 32'h0, 1'b0})
      $display("FAIL reset_b_bus: got %h required %h", {tx_b, addr_b, data_b, we_b}, {1'b1, 37'h0});
    else n_pass++;
    n_chk++;
    if ({flags(0), flags(1)} !== 8'h00) $display("FAIL reset_flags: got %h required 00", {flags(0), flags(1)});
    else n_pass++;
    rst = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_frame_ack();
    words = '{32'h1234, 32'h5678};
    make_frame(0, 16'h0010, 1'b0);
    send_byte(0, frm[0], 1'b1);
    n_chk++;
    if (hold_a !== 1'b1 || busy_a !== 1'b1) $display("FAIL ack_hold_after_sync: got %b%b required 11", hold_a, busy_a);
    else n_pass++;
    frm.pop_front();
    foreach (frm[i]) send_byte(0, frm[i], 1'b1);
    wait_collect(0, 14 * DIV);
    n_chk++;
    if (got_wr.size() != 2 || got_wr[0] !== 48'h0010_00001234 || got_wr[1] !== 48'h0011_00005678)
      $display("FAIL ack_writes: got %0d writes first %h required 2 writes 0010_00001234,0011_00005678",
               got_wr.size(), (got_wr.size() > 0) ? got_wr[0] : 48'hx);
    else n_pass++;
    n_chk++;
    if (got_rep.size() != 1 || rep0() !== 8'h06) $display("FAIL ack_reply: got %0d bytes %h required 06", got_rep.size(), rep0());
    else n_pass++;
    n_chk++;
    if (got_hb.size() != 1 || got_hb[0] !== 1'b1) $display("FAIL ack_hold_in_stop: got %0d samples required hold 1", got_hb.size());
    else n_pass++;
    n_chk++;
    if (flags(0) !== 4'b0000) $display("FAIL ack_flags_after: got %b required 0000", flags(0));
    else n_pass++;
  endtask

  task automatic test_bad_chk();
    words = '{32'h1234, 32'h5678};
    make_frame(0, 16'h0010, 1'b0);
    frm[frm.size() - 1] = 8'h00;
    send_frm(0);
    wait_collect(0, 14 * DIV);
    n_chk++;
    if (got_wr.size() != 2 || got_wr[0] !== 48'h0010_00001234 || got_wr[1] !== 48'h0011_00005678)
      $display("FAIL nak_writes: got %0d writes required 2", got_wr.size());
    else n_pass++;
    n_chk++;
    if (got_rep.size() != 1 || rep0() !== 8'h15) $display("FAIL nak_reply: got %0d bytes %h required 15", got_rep.size(), rep0());
    else n_pass++;
    n_chk++;
    if (flags(0) !== 4'b0010) $display("FAIL nak_flags: got %b required 0010", flags(0));
    else n_pass++;
  endtask

  task automatic test_wrap_le();
    words = '{32'h04030201, 32'h08070605};
    make_frame(1, 16'h000F, 1'b0);
    send_frm(1);
    wait_collect(1, 14 * DIV);
    n_chk++;
    if (got_wr.size() != 2 || got_wr[0] !== 48'h000F_04030201 || got_wr[1] !== 48'h0000_08070605)
      $display("FAIL wrap_writes: got %0d writes first %h required 000F_04030201,0000_08070605",
               got_wr.size(), (got_wr.size() > 0) ? got_wr[0] : 48'hx);
    else n_pass++;
    n_chk++;
    if (got_rep.size() != 1 || rep0() !== 8'h06) $display("FAIL wrap_reply: got %0d bytes %h required 06", got_rep.size(), rep0());
    else n_pass++;
  endtask

  task automatic test_timeout();
    frm = '{8'hA5, 8'h00, 8'h00};
    send_frm(0);
    repeat (TO / 2) @(negedge clk);
    n_chk++;
    if (flags(0) !== 4'b1100) $display("FAIL timeout_early: got %b required 1100", flags(0));
    else n_pass++;
    repeat (TO) @(negedge clk);
    n_chk++;
    if (flags(0) !== 4'b0001) $display("FAIL timeout_abort: got %b required 0001", flags(0));
    else n_pass++;
    n_chk++;
    if (rep_a.size() != 0 || wr_a.size() != 0 || tx_a !== 1'b1)
      $display("FAIL timeout_quiet: got %0d replies %0d writes required 0 0", rep_a.size(), wr_a.size());
    else n_pass++;
  endtask

  task automatic test_ignore_lead();
    words.delete();
    make_frame(0, 16'h0020, 1'b0);
    frm.push_front(8'h44);
    frm.push_front(8'h33);
    send_frm(0);
    wait_collect(0, 14 * DIV);
    n_chk++;
    if (got_wr.size() != 0) $display("FAIL cnt0_writes: got %0d required 0", got_wr.size());
    else n_pass++;
    n_chk++;
    if (got_rep.size() != 1 || rep0() !== 8'h06) $display("FAIL cnt0_reply: got %0d bytes %h required 06", got_rep.size(), rep0());
    else n_pass++;
    n_chk++;
    if (flags(0) !== 4'b0000) $display("FAIL cnt0_flags: got %b required 0000", flags(0));
    else n_pass++;
  endtask

  task automatic test_stop_err();
    frm = '{8'hA5, 8'h00, 8'h30, 8'h00, 8'h02, 8'h11};
    send_frm(0);
    send_byte(0, 8'h22, 1'b0);
    n_chk++;
    if (flags(0) !== 4'b0001) $display("FAIL stoperr_flags: got %b required 0001", flags(0));
    else n_pass++;
    repeat (300) @(negedge clk);
    n_chk++;
    if (rep_a.size() != 0 || wr_a.size() != 0)
      $display("FAIL stoperr_quiet: got %0d replies %0d writes required 0 0", rep_a.size(), wr_a.size());
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    words = '{$urandom, $urandom, $urandom};
    make_frame(1, 16'h0003, 1'b0);
    wr_b.delete();
    rep_b.delete();
    for (int i = 0; i < 11; i++) send_byte(1, frm[i], 1'b1);
    n_chk++;
    if (wr_b.size() != 1 || wr_b[0] !== exp_wr[0])
      $display("FAIL rstmid_first_write: got %0d writes required 1 of %h", wr_b.size(), exp_wr[0]);
    else n_pass++;
    n_chk++;
    if (flags(1) !== 4'b1100) $display("FAIL rstmid_inframe: got %b required 1100", flags(1));
    else n_pass++;
    rst = 1'b1;
    #1;
    n_chk++;
    if ({tx_b, addr_b, data_b, we_b, flags(1)} !== {1'b1, 4'h0, 32'h0, 1'b0, 4'h0})
      $display("FAIL rstmid_outputs: got %h required %h", {tx_b, addr_b, data_b, we_b, flags(1)}, {1'b1, 41'h0});
    else n_pass++;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 11; i < frm.size(); i++) send_byte(1, frm[i], 1'b1);
    repeat (300) @(negedge clk);
    n_chk++;
    if (wr_b.size() != 1 || rep_b.size() != 0)
      $display("FAIL rstmid_abandoned: got %0d writes %0d replies required 1 0", wr_b.size(), rep_b.size());
    else n_pass++;
  endtask

  task automatic test_random_frames();
    int which, n;
    bit bad;
    logic [15:0] a;
    for (int f = 0; f < 8; f++) begin
      which = f % 2;
      n = $urandom_range(0, 4);
      bad = ($urandom_range(0, 2) == 0);
      a = 16'($urandom);
      words.delete();
      for (int k = 0; k < n; k++) words.push_back((which != 0) ? $urandom : {16'h0, 16'($urandom)});
      make_frame(which, a, bad);
      send_frm(which);
      wait_collect(which, 14 * DIV);
      n_chk++;
      if (got_wr.size() != exp_wr.size()) $display("FAIL rand%0d_count: got %0d required %0d", f, got_wr.size(), exp_wr.size());
      else n_pass++;
      foreach (exp_wr[k]) begin
        n_chk++;
        if (k >= got_wr.size() || got_wr[k] !== exp_wr[k])
          $display("FAIL rand%0d_write%0d: got %h required %h", f, k, (k < got_wr.size()) ? got_wr[k] : 48'hx, exp_wr[k]);
        else n_pass++;
      end
      n_chk++;
      if (got_rep.size() != 1 || rep0() !== exp_rep)
        $display("FAIL rand%0d_reply: got %0d bytes %h required %h", f, got_rep.size(), rep0(), exp_rep);
      else n_pass++;
      n_chk++;
      if (flags(which) !== {3'b000, 1'b0} + {2'b00, bad, 1'b0})
        $display("FAIL rand%0d_flags: got %b required %b", f, flags(which), {2'b00, bad, 1'b0});
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_frame_ack();
    test_bad_chk();
    test_wrap_le();
    test_timeout();
    test_ignore_lead();
    test_stop_err();
    test_reset_mid();
    test_random_frames();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
